// File: rtl/countdown_pkg.sv
`default_nettype none
// ============================================================================
// Module      : countdown_pkg
// Description : Shared types and constants for the BCD countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam int   DVSR_DEFAULT = 5000000;
    localparam bcd_t BCD_MAX      = 4'd9;

    function automatic bcd_t bcd_clamp(input logic [3:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_down_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_down_digit
// Description : One BCD digit that decrements with wrap 0 -> 9 and borrow out.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_down_digit
    import countdown_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] din,
    input  logic       dec_en,
    output logic [3:0] q,
    output logic       borrow,
    output logic       is_zero
);

    bcd_t r_q_q;
    bcd_t w_q_d;

    always_comb begin
        w_q_d = r_q_q;
        if (clr) begin
            w_q_d = 4'd0;
        end else if (load) begin
            w_q_d = din;
        end else if (dec_en) begin
            w_q_d = (r_q_q == 4'd0) ? BCD_MAX : r_q_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q_q <= 4'd0;
        end else begin
            r_q_q <= w_q_d;
        end
    end

    assign q       = r_q_q;
    assign is_zero = (r_q_q == 4'd0);
    assign borrow  = dec_en && is_zero;

endmodule
`default_nettype wire

// File: rtl/countdown_timer_bcd.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_bcd
// Description : Three-digit BCD countdown timer, 0.1 s resolution, with expiry.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer_bcd
    import countdown_pkg::*;
#(
    parameter int DVSR = DVSR_DEFAULT
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] din2,
    input  logic [3:0] din1,
    input  logic [3:0] din0,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       running,
    output logic       expired,
    output logic       done_tick
);

    localparam int             PW        = $clog2(DVSR);
    localparam logic [PW-1:0]  C_MS_LAST = PW'(DVSR - 1);

    state_e          r_state_q;
    state_e          w_state_d;
    logic [PW-1:0]   r_ms_q;
    logic [PW-1:0]   w_ms_d;
    logic            r_running_q;
    logic            r_expired_q;
    logic            r_done_q;

    bcd_t            w_q2, w_q1, w_q0;
    logic            w_z2, w_z1, w_z0;
    logic            w_b0, w_b1, w_unused_borrow2;
    logic            w_tick;
    logic            w_dec;
    logic            w_count_zero;
    logic            w_at_one;
    logic            w_terminal;

    assign w_tick       = (r_state_q == RUN) && (r_ms_q == C_MS_LAST);
    assign w_count_zero = w_z2 && w_z1 && w_z0;
    assign w_at_one     = w_z2 && w_z1 && (w_q0 == 4'd1);
    // Never decrement from 000, so the count cannot wrap to 999
    assign w_dec        = w_tick && !w_count_zero;
    assign w_terminal   = w_tick && w_at_one && !clr && !load;

    bcd_down_digit u_digit0 (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .load    (load),
        .din     (bcd_clamp(din0)),
        .dec_en  (w_dec),
        .q       (w_q0),
        .borrow  (w_b0),
        .is_zero (w_z0)
    );

    bcd_down_digit u_digit1 (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .load    (load),
        .din     (bcd_clamp(din1)),
        .dec_en  (w_b0),
        .q       (w_q1),
        .borrow  (w_b1),
        .is_zero (w_z1)
    );

    bcd_down_digit u_digit2 (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .load    (load),
        .din     (bcd_clamp(din2)),
        .dec_en  (w_b1),
        .q       (w_q2),
        .borrow  (w_unused_borrow2),
        .is_zero (w_z2)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_ms_d    = r_ms_q;
        if (clr || load) begin
            w_state_d = IDLE;
            w_ms_d    = '0;
        end else begin
            if (r_state_q == RUN) begin
                w_ms_d = (r_ms_q == C_MS_LAST) ? '0 : r_ms_q + PW'(1);
            end
            case (r_state_q)
                IDLE: begin
                    if (start && !w_count_zero) begin
                        w_state_d = RUN;
                    end
                end
                RUN: begin
                    // Reaching zero takes precedence over a coincident stop
                    if (w_terminal) begin
                        w_state_d = EXPIRED;
                    end else if (stop) begin
                        w_state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (start && !stop) begin
                        w_state_d = RUN;
                    end
                end
                default: begin
                    w_state_d = r_state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q   <= IDLE;
            r_ms_q      <= '0;
            r_running_q <= 1'b0;
            r_expired_q <= 1'b0;
            r_done_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_ms_q      <= w_ms_d;
            r_running_q <= (w_state_d == RUN);
            r_expired_q <= (w_state_d == EXPIRED);
            r_done_q    <= w_terminal;
        end
    end

    assign d2        = w_q2;
    assign d1        = w_q1;
    assign d0        = w_q0;
    assign running   = r_running_q;
    assign expired   = r_expired_q;
    assign done_tick = r_done_q;

endmodule
`default_nettype wire

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
Three-digit BCD countdown timer with 0.1 s resolution (range 00.0 s to 99.9 s). It is the counting-down counterpart of the team's cascaded up-counting stopwatch. It loads a preset, counts down while running and signals expiry. It drives the same seven-segment display multiplexer through d2/d1/d0.

Parameters:
DVSR, 5000000, prescaler period in clk cycles per 0.1 s tick (50 MHz clock); must be >= 2
PW, $clog2(DVSR), prescaler register width (derived, not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
clr  input  1  synchronous clear: digits to 000, state IDLE
load  input  1  synchronous load of din2/din1/din0, state IDLE
din2  input  4  preset tens-of-seconds digit (BCD)
din1  input  4  preset seconds digit (BCD)
din0  input  4  preset tenths digit (BCD)
start  input  1  single-cycle pulse: begin/resume counting
stop  input  1  single-cycle pulse: pause counting
d2  output  4  current tens-of-seconds digit
d1  output  4  current seconds digit
d0  output  4  current tenths digit
running  output  1  high while state is RUN
expired  output  1  high while state is EXPIRED
done_tick  output  1  one-cycle pulse when the count reaches 000

Behaviour:
- Reset (async, immediate): state=IDLE; ms_reg=0; d2/d1/d0=0; running=0, expired=0, done_tick=0.
- FSM states: IDLE, RUN, PAUSE, EXPIRED. Registered state; running/expired are decoded from state.
- Input priority each cycle: clr > load > stop > start.
- clr (any state): digits=000, ms_reg=0, next state IDLE.
- load (any state): digits=din*, ms_reg=0, next state IDLE. A din digit >9 is clamped to 9 per digit.
- IDLE:
  - start with count !=000 -> RUN.
  - start with count ==000 -> stays IDLE; no done_tick.
- RUN:
  - stop -> PAUSE.
  - start is ignored.
  - start and stop in the same cycle -> PAUSE.
- PAUSE:
  - start -> RUN.
  - stop is ignored.
  - start and stop in the same cycle -> stays PAUSE.
- EXPIRED: start and stop are ignored. Leaves only on clr or load.
- Prescaler:
  - In RUN, ms_reg increments each cycle and wraps from DVSR-1 to 0.
  - tick = (state==RUN && ms_reg==DVSR-1).
  - In IDLE/PAUSE/EXPIRED, ms_reg holds. Pause therefore preserves the sub-tick phase.
- Decrement on tick:
  - d0 decrements; d0 at 0 wraps to 9 and borrows.
  - d1 decrements only on a d0 borrow; d1 at 0 wraps to 9 and borrows.
  - d2 decrements only on a d1 borrow.
  - Digits update on the clock edge where tick is high (1-cycle latency from the tick condition).
- Expiry:
  - If tick occurs with count ==001, digits become 000, state becomes EXPIRED and done_tick is high for exactly that one following cycle (registered).
  - Count never wraps below 000.
- The terminal tick and clr/load in the same cycle: clr/load win; no done_tick.
- Digits are always valid BCD (0-9). Illegal values are not reachable after reset.

Decomposition:
- Package countdown_pkg: state enum (IDLE, RUN, PAUSE, EXPIRED), 4-bit BCD digit typedef, DVSR_DEFAULT constant, BCD_MAX=9.
- Sub-module bcd_down_digit (one instance per digit, three total).
  - Inputs: clk, reset, clr, load, din, dec_en.
  - Outputs: q, borrow (= dec_en && q==0), is_zero.
- Top level: FSM, prescaler, borrow chaining, clamp, done_tick register.

Test Plan (DVSR=4 in simulation):
1. load 0,1,2 then start -> running=1; count reaches 000 exactly 12x4=48 cycles after RUN entry; done_tick high for exactly 1 cycle; expired=1, running=0.
2. load 1,0,0, start -> first tick gives 0,9,9; next tick gives 0,9,8. Check d2/d1/d0 at each edge.
3. Run from 005, stop after 6 cycles, idle 100 cycles (digits frozen, running=0), then start -> expiry after 20 total RUN cycles.
4. start with 000 -> state stays IDLE, running=0, no done_tick. start in EXPIRED is ignored. start+stop together in RUN -> PAUSE.
5. clr during RUN at 047 -> 000, IDLE, no done_tick. load din0=4'hC, din1=3, din2=0 -> digits 0,3,9.
6. Assert reset mid-run between clock edges -> d2/d1/d0=0, running=0 before the next clk edge; count resumes only after load and start.
